// File: rtl/psp_mem_pkg.sv
// Shared types and default sizes for the instruction/data memory arbiter.
package psp_mem_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter onto one memory port, with round-robin
// tie-break on contention and a bounded wait for the memory completion.
module mem_arbiter
    import psp_mem_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [DATA_W-1:0]   i_rdata,
    output logic                i_resp,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wmask,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_resp,
    output logic                m_req,
    output logic                m_we,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wmask,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic                m_resp,
    output logic                busy,
    output logic                timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    grant_t           last_grant;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= GRANT_I;
            cnt         <= '0;
            i_rdata     <= '0;
            i_resp      <= 1'b0;
            d_rdata     <= '0;
            d_resp      <= 1'b0;
            m_req       <= 1'b0;
            m_we        <= 1'b0;
            m_addr      <= '0;
            m_wdata     <= '0;
            m_wmask     <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            i_resp      <= 1'b0;
            d_resp      <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    // Data wins unless it was the one served at the last contention.
                    if (d_req && (!i_req || last_grant == GRANT_I)) begin
                        state   <= BUSY_D;
                        busy    <= 1'b1;
                        m_req   <= 1'b1;
                        m_we    <= d_we;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                        m_wmask <= d_wmask;
                        cnt     <= '0;
                        if (i_req) begin
                            last_grant <= GRANT_D;
                        end
                    end else if (i_req) begin
                        state   <= BUSY_I;
                        busy    <= 1'b1;
                        m_req   <= 1'b1;
                        m_we    <= 1'b0;
                        m_addr  <= i_addr;
                        m_wdata <= '0;
                        m_wmask <= '0;
                        cnt     <= '0;
                        if (d_req) begin
                            last_grant <= GRANT_I;
                        end
                    end
                end
                BUSY_I, BUSY_D: begin
                    // A completion on the final allowed cycle still counts as success.
                    if (m_resp) begin
                        m_req <= 1'b0;
                        state <= RESP;
                        if (state == BUSY_D) begin
                            d_rdata <= m_rdata;
                            d_resp  <= 1'b1;
                        end else begin
                            i_rdata <= m_rdata;
                            i_resp  <= 1'b1;
                        end
                    end else if (cnt == CNT_LAST) begin
                        m_req       <= 1'b0;
                        state       <= RESP;
                        timeout_err <= 1'b1;
                        if (state == BUSY_D) begin
                            d_rdata <= '0;
                            d_resp  <= 1'b1;
                        end else begin
                            i_rdata <= '0;
                            i_resp  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    m_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table of single transactions,
// contention sequences, spurious completion and mid-transaction reset.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_resp;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [3:0]    d_wmask;
    logic [DW-1:0] d_rdata;
    logic          d_resp;
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [3:0]    m_wmask;
    logic [DW-1:0] m_rdata;
    logic          m_resp;
    logic          busy;
    logic          timeout_err;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wmask(d_wmask), .d_rdata(d_rdata), .d_resp(d_resp),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wmask(m_wmask), .m_rdata(m_rdata), .m_resp(m_resp),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          is_d;
        logic          we;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic [3:0]    wmask;
        int            lat;     // m_req cycle carrying m_resp; 0 = never answer
        logic [31:0]   rdata;
    } vec_t;

    typedef struct {
        logic        is_d;
        logic [31:0] rdata;
        logic        to;
    } sb_t;

    sb_t          exp_q[$];
    logic [31:0]  mem_data_q[$];
    int           mem_lat = 0;
    int           mem_cnt = 0;
    logic [31:0]  last_i = 32'h0;
    logic [31:0]  last_d = 32'h0;
    int           n_cmp = 0;
    int           n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: observe at the falling edge, score completions, then drive memory.
    task automatic step();
        sb_t e;
        @(negedge clk);
        if (i_resp || d_resp) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_resp: got i_resp=%0b d_resp=%0b expected none", i_resp, d_resp);
            end else begin
                e = exp_q.pop_front();
                chk("resp_side", 32'({i_resp, d_resp}), e.is_d ? 32'd1 : 32'd2);
                chk("resp_rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
                chk("timeout_err", 32'(timeout_err), 32'(e.to));
                if (e.is_d) last_d = e.rdata;
                else        last_i = e.rdata;
            end
        end
        m_resp  = 1'b0;
        m_rdata = 32'hFFFF_0000;
        if (m_req && !reset) begin
            mem_cnt++;
            if (mem_cnt == mem_lat) begin
                m_resp  = 1'b1;
                m_rdata = (mem_data_q.size() > 0) ? mem_data_q.pop_front() : 32'h0;
            end
        end else begin
            mem_cnt = 0;
        end
    endtask

    task automatic do_txn(input vec_t v, input int idx);
        sb_t         e;
        int          cyc = 0;
        int          mreq_cyc = 0;
        int          resp_cyc = 0;
        int          eff;
        logic [31:0] ew;
        logic [3:0]  em;
        logic        ewe;
        eff     = (v.lat == 0) ? TO : v.lat;
        e.is_d  = v.is_d;
        e.to    = (v.lat == 0);
        e.rdata = e.to ? 32'h0 : v.rdata;
        exp_q.push_back(e);
        if (!e.to) mem_data_q.push_back(v.rdata);
        mem_lat = v.lat;
        ewe = v.is_d ? v.we : 1'b0;
        ew  = v.is_d ? v.wdata : 32'h0;
        em  = v.is_d ? v.wmask : 4'h0;
        if (v.is_d) begin
            d_addr = v.addr; d_we = v.we; d_wdata = v.wdata; d_wmask = v.wmask; d_req = 1'b1;
        end else begin
            i_addr = v.addr; i_req = 1'b1;
        end
        while (resp_cyc == 0 && cyc < 40) begin
            step();
            cyc++;
            if (cyc == 1) chk("m_req_latency", 32'(m_req), 32'd1);
            if (m_req) begin
                mreq_cyc++;
                chk("m_addr", m_addr, v.addr);
                chk("m_we", 32'(m_we), 32'(ewe));
                chk("m_wdata", m_wdata, ew);
                chk("m_wmask", 32'(m_wmask), 32'(em));
            end
            if (i_resp || d_resp) begin
                resp_cyc = cyc;
                chk("busy_in_resp", 32'(busy), 32'd1);
            end
        end
        chk("resp_cycle", 32'(resp_cyc), 32'(eff + 1));
        chk("m_req_cycles", 32'(mreq_cyc), 32'(eff));
        i_req = 1'b0;
        d_req = 1'b0;
        step();
        chk("busy_after", 32'(busy), 32'd0);
        chk("i_rdata_hold", i_rdata, last_i);
        chk("d_rdata_hold", d_rdata, last_d);
        $display("txn %0d: %s addr=0x%08h lat=%0d resp_cycle=%0d i_rdata=0x%08h d_rdata=0x%08h",
                 idx, v.is_d ? "D" : "I", v.addr, v.lat, resp_cyc, i_rdata, d_rdata);
    endtask

    // Both requesters held high; grants must alternate starting with D.
    task automatic contend(input int n);
        int seen = 0;
        int cyc = 0;
        sb_t e;
        for (int k = 0; k < n; k++) begin
            e.is_d  = (k % 2 == 0);
            e.rdata = 32'h11 * (k + 1);
            e.to    = 1'b0;
            exp_q.push_back(e);
            mem_data_q.push_back(e.rdata);
        end
        mem_lat = 2;
        i_addr = 32'h1000; d_addr = 32'h2000; d_we = 1'b0; d_wdata = '0; d_wmask = '0;
        i_req = 1'b1; d_req = 1'b1;
        while (seen < n && cyc < 100) begin
            step();
            cyc++;
            if (m_req && exp_q.size() > 0)
                chk("grant_addr", m_addr, exp_q[0].is_d ? 32'h2000 : 32'h1000);
            if (i_resp || d_resp) begin
                seen++;
                $display("contend grant %0d: i_resp=%0b d_resp=%0b i_rdata=0x%08h d_rdata=0x%08h",
                         seen, i_resp, d_resp, i_rdata, d_rdata);
            end
        end
        chk("contend_done", 32'(seen), 32'(n));
        i_req = 1'b0;
        d_req = 1'b0;
        step();
        step();
        chk("contend_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[7];
        vecs[0] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 3, 32'hCAFE_0001};
        vecs[1] = '{1'b0, 1'b0, 32'h0000_2000, 32'h0,         4'h0, 1, 32'h1234_5678};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0044, 32'h0BAD_0BAD, 4'h3, 5, 32'hA5A5_A5A5};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_3000, 32'h0,         4'h0, 0, 32'h9999_9999};
        vecs[4] = '{1'b1, 1'b0, 32'h0000_0048, 32'h0,         4'h0, TO, 32'h0BAD_F00D};
        vecs[5] = '{1'b1, 1'b1, 32'h0000_0200, 32'h5A5A_5A5A, 4'h6, 0, 32'h7777_7777};
        vecs[6] = '{1'b0, 1'b0, 32'h0000_4004, 32'h0,         4'h0, TO, 32'h0000_0077};

        reset = 1'b1;
        i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0;
        d_wdata = '0; d_wmask = '0; m_rdata = '0; m_resp = 1'b0;
        step();
        step();
        chk("rst_m_req", 32'(m_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resps", 32'({i_resp, d_resp, timeout_err}), 32'd0);
        chk("rst_i_rdata", i_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_m_addr", m_addr, 32'h0);
        reset = 1'b0;

        contend(3);

        for (int k = 0; k < 7; k++) do_txn(vecs[k], k);

        // Spurious completion while idle must be ignored.
        m_resp  = 1'b1;
        m_rdata = 32'h5555_AAAA;
        step();
        chk("spur_busy", 32'(busy), 32'd0);
        chk("spur_resps", 32'({i_resp, d_resp, timeout_err}), 32'd0);
        step();
        chk("spur_busy2", 32'(busy), 32'd0);
        chk("spur_i_rdata", i_rdata, last_i);
        chk("spur_d_rdata", d_rdata, last_d);
        $display("spurious m_resp in IDLE: busy=%0b i_rdata=0x%08h d_rdata=0x%08h", busy, i_rdata, d_rdata);

        // Reset in the middle of a data transaction drops it without a response.
        mem_lat = 0;
        d_addr = 32'h300; d_we = 1'b0; d_req = 1'b1;
        step();
        step();
        chk("mid_m_req_before", 32'(m_req), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_m_req", 32'(m_req), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_d_resp", 32'(d_resp), 32'd0);
        d_req = 1'b0;
        step();
        step();
        reset = 1'b0;
        last_i = 32'h0;
        last_d = 32'h0;
        chk("mid_d_rdata", d_rdata, 32'h0);
        $display("reset mid BUSY_D: m_req=%0b busy=%0b d_resp=%0b", m_req, busy, d_resp);

        contend(2);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
